// File: rtl/pmem_responder_pkg.sv
// rtl/pmem_responder_pkg.sv - shared types for the physical-memory line responder
//
// Package lc3b_types:
//   lc3b_pmem_line     128-bit cache line as seen on the pmem interface
//   PMEM_OFFSET_BITS   byte-offset bits inside one line (16-byte lines)
//   pmem_resp_state_t  responder FSM states IDLE / BUSY / RESP
//   sat_inc16()        16-bit saturating increment used by the statistics counters

package lc3b_types;

    typedef logic [127:0] lc3b_pmem_line;

    localparam int PMEM_OFFSET_BITS = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } pmem_resp_state_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        return (value == 16'hFFFF) ? value : value + 16'd1;
    endfunction

endpackage

// File: rtl/pmem_responder_line_store.sv
// rtl/pmem_responder_line_store.sv - single-port backing store of 128-bit lines
//
// Module pmem_line_store (parameter LINE_BITS: log2 of the line count)
//   clk    in   rising-edge clock
//   we     in   write enable; stores wdata at index on the edge
//   re     in   read enable; loads rdata from index on the edge
//   index  in   line index
//   wdata  in   line to store
//   rdata  out  registered read line, holds its value between reads
//
// The array carries no reset: its contents survive rst_n. The owner never
// raises we and re together; if it did, the write would win.

module pmem_line_store
    import lc3b_types::*;
#(
    parameter int LINE_BITS = 8
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic                 re,
    input  logic [LINE_BITS-1:0] index,
    input  lc3b_pmem_line        wdata,
    output lc3b_pmem_line        rdata
);

    localparam int DEPTH = 1 << LINE_BITS;

    lc3b_pmem_line mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[index] <= wdata;
        end else if (re) begin
            rdata <= mem[index];
        end
    end

endmodule

// File: rtl/pmem_responder.sv
// rtl/pmem_responder.sv - main-memory stand-in answering cache line reads/writes after a fixed latency
//
// Parameters:
//   LATENCY    cycles from the acceptance edge to the pmem_resp pulse (1..255)
//   LINE_BITS  log2 of the number of 16-byte lines in the backing store
// Ports:
//   clk           in   rising-edge clock
//   rst_n         in   synchronous active-low reset (store contents are kept)
//   pmem_read     in   line read request, held until pmem_resp
//   pmem_write    in   line write request, held until pmem_resp
//   pmem_address  in   byte address; line index is [LINE_BITS+3:4], higher bits alias
//   pmem_wdata    in   line to write
//   pmem_rdata    out  read line, valid while pmem_resp is high (zero otherwise)
//   pmem_resp     out  one-cycle completion pulse
//   protocol_err  out  one-cycle pulse: read+write together at acceptance, or
//                      request dropped before completion
//   read_count    out  completed reads, saturating   (PMEM_RESPONDER_STATS_EN only)
//   write_count   out  completed writes, saturating  (PMEM_RESPONDER_STATS_EN only)
//
// Build option: define PMEM_RESPONDER_STATS_EN to add the completion counters.

module pmem_responder
    import lc3b_types::*;
#(
    parameter int LATENCY   = 4,
    parameter int LINE_BITS = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pmem_read,
    input  logic          pmem_write,
    input  logic [15:0]   pmem_address,
    input  lc3b_pmem_line pmem_wdata,
    output lc3b_pmem_line pmem_rdata,
    output logic          pmem_resp,
`ifdef PMEM_RESPONDER_STATS_EN
    output logic [15:0]   read_count,
    output logic [15:0]   write_count,
`endif
    output logic          protocol_err
);

    localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 1);

    pmem_resp_state_t     state;
    logic [7:0]           count;
    logic                 op_write;
    logic [LINE_BITS-1:0] idx_q;
    lc3b_pmem_line        wdata_q;

    logic                 req;
    logic [LINE_BITS-1:0] addr_idx;
    logic                 addr_unused;

    logic                 store_we;
    logic                 store_re;
    logic [LINE_BITS-1:0] store_index;
    lc3b_pmem_line        store_rdata;

    assign req         = pmem_read | pmem_write;
    assign addr_idx    = pmem_address[LINE_BITS+PMEM_OFFSET_BITS-1:PMEM_OFFSET_BITS];
    // Offset and aliasing bits are deliberately ignored.
    assign addr_unused = ^pmem_address;

    // Control FSM and latency counter. RESP is entered on the edge that takes
    // count to zero, so the pulse lands in the LATENCY-th cycle after the
    // acceptance edge; LATENCY=1 has no BUSY cycles at all.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            count        <= 8'd0;
            protocol_err <= 1'b0;
        end else begin
            protocol_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        protocol_err <= pmem_read & pmem_write;
                        if (LATENCY == 1) begin
                            state <= RESP;
                        end else begin
                            state <= BUSY;
                            count <= COUNT_LOAD;
                        end
                    end
                end
                BUSY: begin
                    if (!req) begin
                        // Cache gave up: abandon the transaction, nothing is committed.
                        state        <= IDLE;
                        count        <= 8'd0;
                        protocol_err <= 1'b1;
                    end else begin
                        count <= count - 8'd1;
                        if (count == 8'd1) begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    count <= 8'd0;
                end
            endcase
        end
    end

    // Request capture: a simultaneous read+write is taken as a write. Later
    // changes on the bus while BUSY are ignored.
    always_ff @(posedge clk) begin
        if (state == IDLE && req) begin
            op_write <= pmem_write;
            idx_q    <= addr_idx;
            wdata_q  <= pmem_wdata;
        end
    end

    // Store sequencing. The read is launched on the edge entering RESP so the
    // registered store output lines up with pmem_resp; the write is committed
    // on the edge leaving RESP. Both are suppressed while rst_n is low.
    always_comb begin
        store_re    = 1'b0;
        store_we    = 1'b0;
        store_index = idx_q;
        if (state == IDLE) begin
            store_index = addr_idx;
        end
        if (rst_n) begin
            if (state == IDLE && LATENCY == 1 && req && !pmem_write) begin
                store_re = 1'b1;
            end
            if (state == BUSY && req && count == 8'd1 && !op_write) begin
                store_re = 1'b1;
            end
            if (state == RESP && op_write) begin
                store_we = 1'b1;
            end
        end
    end

    pmem_line_store #(
        .LINE_BITS (LINE_BITS)
    ) u_store (
        .clk   (clk),
        .we    (store_we),
        .re    (store_re),
        .index (store_index),
        .wdata (wdata_q),
        .rdata (store_rdata)
    );

    assign pmem_resp  = (state == RESP);
    assign pmem_rdata = (pmem_resp && !op_write) ? store_rdata : '0;

`ifdef PMEM_RESPONDER_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            read_count  <= 16'd0;
            write_count <= 16'd0;
        end else if (state == RESP) begin
            if (op_write) begin
                write_count <= sat_inc16(write_count);
            end else begin
                read_count <= sat_inc16(read_count);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// tb/tb_pmem_responder.sv - self-checking bench for pmem_responder (LATENCY=4 and LATENCY=1 instances)

module tb_pmem_responder;

    localparam int L0 = 4;
    localparam int L1 = 1;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         rd    [2];
    logic         wr    [2];
    logic [15:0]  addr  [2];
    logic [127:0] wd    [2];
    logic [127:0] rdata [2];
    logic         resp  [2];
    logic         err   [2];
`ifdef PMEM_RESPONDER_STATS_EN
    logic [15:0]  rcount [2];
    logic [15:0]  wcount [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pmem_responder #(.LATENCY(L0), .LINE_BITS(8)) u_l4 (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (rd[0]),
        .pmem_write   (wr[0]),
        .pmem_address (addr[0]),
        .pmem_wdata   (wd[0]),
        .pmem_rdata   (rdata[0]),
        .pmem_resp    (resp[0]),
`ifdef PMEM_RESPONDER_STATS_EN
        .read_count   (rcount[0]),
        .write_count  (wcount[0]),
`endif
        .protocol_err (err[0])
    );

    pmem_responder #(.LATENCY(L1), .LINE_BITS(8)) u_l1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .pmem_read    (rd[1]),
        .pmem_write   (wr[1]),
        .pmem_address (addr[1]),
        .pmem_wdata   (wd[1]),
        .pmem_rdata   (rdata[1]),
        .pmem_resp    (resp[1]),
`ifdef PMEM_RESPONDER_STATS_EN
        .read_count   (rcount[1]),
        .write_count  (wcount[1]),
`endif
        .protocol_err (err[1])
    );

    function automatic int lat_of(input int i);
        return (i == 0) ? L0 : L1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Transaction-level reference: a request accepted at an edge answers in
    // the LATENCY-th following cycle unless dropped or reset first; writes
    // land in the line array when the response cycle ends.
    int           cyc = 0;
    bit           mon_on = 0;
    bit           act   [2];
    int           age   [2];
    bit           m_w   [2];
    logic [7:0]   m_idx [2];
    logic [127:0] m_d   [2];
    bit           e_resp[2];
    bit           e_err [2];
    int           n_rd  [2];
    int           n_wr  [2];
    logic [127:0] mmem  [2][256];
    bit           mknown[2][256];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            e_err[i] = 1'b0;
            if (!rst_n) begin
                act[i]  = 1'b0;
                age[i]  = 0;
                n_rd[i] = 0;
                n_wr[i] = 0;
            end else if (act[i] && age[i] == lat_of(i)) begin
                if (m_w[i]) begin
                    mmem[i][m_idx[i]]   = m_d[i];
                    mknown[i][m_idx[i]] = 1'b1;
                    if (n_wr[i] < 65535) n_wr[i]++;
                end else if (n_rd[i] < 65535) begin
                    n_rd[i]++;
                end
                act[i] = 1'b0;
            end else if (act[i]) begin
                if (!(rd[i] || wr[i])) begin
                    act[i]   = 1'b0;
                    e_err[i] = 1'b1;
                end else begin
                    age[i]++;
                end
            end else if (rd[i] || wr[i]) begin
                act[i]   = 1'b1;
                age[i]   = 1;
                m_w[i]   = wr[i];
                m_idx[i] = addr[i][11:4];
                m_d[i]   = wd[i];
                e_err[i] = rd[i] && wr[i];
            end
            e_resp[i] = act[i] && (age[i] == lat_of(i));
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("resp[%0d] cyc %0d", i, cyc), 128'(resp[i]), 128'(e_resp[i]));
                chk($sformatf("protocol_err[%0d] cyc %0d", i, cyc), 128'(err[i]), 128'(e_err[i]));
                if (e_resp[i] && !m_w[i] && mknown[i][m_idx[i]])
                    chk($sformatf("rdata[%0d] cyc %0d", i, cyc), rdata[i], mmem[i][m_idx[i]]);
`ifdef PMEM_RESPONDER_STATS_EN
                chk($sformatf("read_count[%0d] cyc %0d", i, cyc), 128'(rcount[i]), 128'(n_rd[i]));
                chk($sformatf("write_count[%0d] cyc %0d", i, cyc), 128'(wcount[i]), 128'(n_wr[i]));
`endif
            end
        end
    end

    // Drives one request from a negedge, the way the cache would. drop_at /
    // rst_at (cycle after acceptance, 0 = never) abandon it or pulse reset.
    // Returns at a negedge in the cycle after the response (or after a bound).
    task automatic txn(input int i, input bit r, input bit w, input logic [15:0] a,
                       input logic [127:0] d, input int drop_at, input int rst_at,
                       input bit scramble, output int lat, output logic [127:0] got,
                       output int nerr, output int nresp, output int at);
        lat = 0; got = '0; nerr = 0; nresp = 0; at = 0;
        rd[i] = r; wr[i] = w; addr[i] = a; wd[i] = d;
        for (int c = 1; c <= lat_of(i) + 4; c++) begin
            @(negedge clk);
            if (!rst_n) rst_n = 1'b1;
            if (err[i] === 1'b1) nerr++;
            if (resp[i] === 1'b1) begin
                nresp++;
                if (lat == 0) begin
                    lat = c;
                    got = rdata[i];
                    at  = cyc;
                end
            end
            if (resp[i] === 1'b1 || c == drop_at || c == rst_at) begin
                rd[i] = 1'b0;
                wr[i] = 1'b0;
            end else if (scramble && $urandom_range(0, 1) == 1) begin
                addr[i] = 16'($urandom);
                wd[i]   = {$urandom, $urandom, $urandom, $urandom};
            end
            if (c == rst_at) rst_n = 1'b0;
            if (resp[i] === 1'b1 && drop_at == 0 && rst_at == 0) begin
                @(negedge clk);
                if (err[i] === 1'b1) nerr++;
                return;
            end
        end
    endtask

    initial begin
        int           lat, nerr, nresp, at0, at1, at2;
        logic [127:0] got;
        logic [127:0] d1, d2, p, d3, d4;
        logic [7:0]   lines [8];

        d1 = 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_0001;
        d2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
        p  = 128'h0F0F_0F0F_A5A5_A5A5_5A5A_5A5A_F0F0_F0F0;
        d3 = 128'hCAFE_F00D_0000_1234_0000_5678_0000_9ABC;
        d4 = 128'h0000_0000_0000_0000_FFFF_0000_4444_0001;
        lines = '{8'h04, 8'h12, 8'h20, 8'h21, 8'h55, 8'h80, 8'hFE, 8'hFF};

        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wd[i] = '0;
        end
        repeat (3) @(negedge clk);
        mon_on = 1'b1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("reset resp[%0d]", i), 128'(resp[i]), 128'd0);
            chk($sformatf("reset protocol_err[%0d]", i), 128'(err[i]), 128'd0);
            chk($sformatf("reset rdata[%0d]", i), rdata[i], 128'd0);
        end
        rst_n = 1'b1;

        // Write then read, LATENCY=4
        txn(0, 0, 1, 16'h0040, d1, 0, 0, 1, lat, got, nerr, nresp, at0);
        chk("wr latency", 128'(lat), 128'd4);
        txn(0, 1, 0, 16'h0040, '0, 0, 0, 1, lat, got, nerr, nresp, at0);
        chk("rd latency", 128'(lat), 128'd4);
        chk("rd data 0040", got, 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_0001);

        // Byte offset ignored
        txn(0, 0, 1, 16'h0123, d2, 0, 0, 0, lat, got, nerr, nresp, at0);
        txn(0, 1, 0, 16'h012F, '0, 0, 0, 0, lat, got, nerr, nresp, at0);
        chk("offset alias data", got, 128'h1111_2222_3333_4444_5555_6666_7777_8888);

        // Abort: all-ones write dropped in BUSY cycle 2
        txn(0, 0, 1, 16'h0200, p, 0, 0, 0, lat, got, nerr, nresp, at0);
        txn(0, 0, 1, 16'h0200, {128{1'b1}}, 2, 0, 0, lat, got, nerr, nresp, at0);
        chk("abort resp count", 128'(nresp), 128'd0);
        chk("abort err count", 128'(nerr), 128'd1);
        txn(0, 1, 0, 16'h0200, '0, 0, 0, 0, lat, got, nerr, nresp, at0);
        chk("abort kept data", got, 128'h0F0F_0F0F_A5A5_A5A5_5A5A_5A5A_F0F0_F0F0);

        // Simultaneous read+write completes as a write
        txn(0, 1, 1, 16'h0300, d3, 0, 0, 0, lat, got, nerr, nresp, at0);
        chk("rdwr err count", 128'(nerr), 128'd1);
        chk("rdwr resp count", 128'(nresp), 128'd1);
        txn(0, 1, 0, 16'h0300, '0, 0, 0, 0, lat, got, nerr, nresp, at0);
        chk("rdwr wrote data", got, 128'hCAFE_F00D_0000_1234_0000_5678_0000_9ABC);

        // Reset in BUSY discards the write
        txn(0, 0, 1, 16'h0040, d2, 0, 2, 0, lat, got, nerr, nresp, at0);
        chk("reset resp count", 128'(nresp), 128'd0);
`ifdef PMEM_RESPONDER_STATS_EN
        chk("reset read_count", 128'(rcount[0]), 128'd0);
        chk("reset write_count", 128'(wcount[0]), 128'd0);
`endif
        txn(0, 1, 0, 16'h0040, '0, 0, 0, 0, lat, got, nerr, nresp, at0);
        chk("reset kept data", got, 128'hDEADBEEF_0123_4567_89AB_CDEF_0000_0001);

        // LATENCY=1 back-to-back reads
        txn(1, 0, 1, 16'h0050, d4, 0, 0, 0, lat, got, nerr, nresp, at0);
        chk("l1 wr latency", 128'(lat), 128'd1);
        txn(1, 1, 0, 16'h0050, '0, 0, 0, 0, lat, got, nerr, nresp, at0);
        chk("l1 rd0 data", got, 128'h0000_0000_0000_0000_FFFF_0000_4444_0001);
        txn(1, 1, 0, 16'h0050, '0, 0, 0, 0, lat, got, nerr, nresp, at1);
        chk("l1 rd1 resps", 128'(nresp), 128'd1);
        txn(1, 1, 0, 16'h0050, '0, 0, 0, 0, lat, got, nerr, nresp, at2);
        chk("l1 rd2 latency", 128'(lat), 128'd1);
        chk("l1 resp spacing 0-1", 128'(at1 - at0), 128'd2);
        chk("l1 resp spacing 1-2", 128'(at2 - at1), 128'd2);

        // Randomized traffic on both instances over a small aliased line set
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 8; j++)
                txn(i, 0, 1, {4'($urandom), lines[j], 4'($urandom)},
                    {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, lat, got, nerr, nresp, at0);
            for (int n = 0; n < 60; n++) begin
                int  k, drop_at, rst_at;
                bit  r, w;
                k = $urandom_range(0, 9);
                r = (k < 5) || (k == 9);
                w = (k >= 5);
                drop_at = 0;
                rst_at  = 0;
                if (lat_of(i) > 1) begin
                    if ($urandom_range(0, 9) == 0) drop_at = $urandom_range(1, lat_of(i) - 1);
                    else if ($urandom_range(0, 29) == 0) rst_at = $urandom_range(1, lat_of(i) - 1);
                end
                txn(i, r, w, {4'($urandom), lines[$urandom_range(0, 7)], 4'($urandom)},
                    {$urandom, $urandom, $urandom, $urandom}, drop_at, rst_at, 1,
                    lat, got, nerr, nresp, at0);
                if (drop_at == 0 && rst_at == 0)
                    chk($sformatf("rand latency[%0d] #%0d", i, n), 128'(lat), 128'(lat_of(i)));
                else
                    chk($sformatf("rand abort resps[%0d] #%0d", i, n), 128'(nresp), 128'd0);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
